// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared state encoding and command layout for the peripheral bus initiator
package periph_bus_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Command word layout, MSB first: {write, addr, wdata}
    function automatic int cmd_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/periph_cmd_fifo.sv
// periph_cmd_fifo: synchronous FIFO holding queued bus commands
module periph_cmd_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rptr_q];
    assign level_o = cnt_q;

    // Storage is not reset; only pointers and count define validity
    always_ff @(posedge clk)
        if (do_push) mem_q[wptr_q] <= din_i;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(do_push);
            rptr_q <= rptr_q + AW'(do_pop);
            cnt_q  <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

endmodule

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: queues read/write commands and plays them onto a peripheral register bus
module periph_bus_initiator
    import periph_bus_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ADDR_W-1:0]        rsp_addr,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        address,
    output logic                     data_write,
    output logic [DATA_W-1:0]        data_in,
    input  logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int CMD_W = cmd_w(ADDR_W, DATA_W);

    logic              fifo_full, fifo_empty, pop, can_issue;
    logic [CMD_W-1:0]  head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
    logic              dwr_q, dwr_d, rv_q, rv_d;

    assign {head_write, head_addr, head_wdata} = head;

    periph_cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && !fifo_full),
        .pop_i   (pop),
        .din_i   ({cmd_write, cmd_addr, cmd_wdata}),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign cmd_ready  = !fifo_full;
    assign busy       = !fifo_empty || state_q != IDLE;
    assign address    = addr_q;
    assign data_write = dwr_q;
    assign data_in    = din_q;
    assign rsp_valid  = rv_q;
    assign rsp_addr   = raddr_q;
    assign rsp_rdata  = rdata_q;

    // Next state: a read in ISSUE captures data_out; otherwise the head is issued whenever allowed
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dwr_d     = 1'b0;
        din_d     = din_q;
        rv_d      = rv_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        pop       = 1'b0;
        can_issue = 1'b0;
        case (state_q)
            WAIT_RSP: begin
                rv_d      = rv_q && !rsp_ready;
                can_issue = rv_q && rsp_ready;
            end
            ISSUE: begin
                can_issue = dwr_q;
                if (!dwr_q) begin
                    rv_d    = 1'b1;
                    raddr_d = addr_q;
                    rdata_d = data_out;
                    state_d = WAIT_RSP;
                end
            end
            default: can_issue = 1'b1;
        endcase
        if (can_issue) begin
            pop     = !fifo_empty;
            state_d = fifo_empty ? IDLE : ISSUE;
            addr_d  = fifo_empty ? addr_q : head_addr;
            dwr_d   = !fifo_empty && head_write;
            din_d   = (!fifo_empty && head_write) ? head_wdata : din_q;
        end
    end

    // Bus, response and state registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dwr_q   <= 1'b0;
            din_q   <= '0;
            rv_q    <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dwr_q   <= dwr_d;
            din_q   <= din_d;
            rv_q    <= rv_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end

endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb_periph_bus_initiator: scoreboarded bench with an ALU-style register peripheral
module tb_periph_bus_initiator;

    typedef struct packed {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [3:0] rsp_addr, address;
    logic [7:0] rsp_rdata, data_in, data_out;
    logic       data_write, busy;
    logic [2:0] level;

    int   checks = 0, errors = 0, wr_cnt = 0, cyc = 0;
    int   wr_cyc[$];
    cmd_t exp_q[$];
    logic [7:0] mdl [16];
    logic [7:0] preg [16];

    periph_bus_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: reg0 = A, reg1 = B, reg2 bit0 selects subtract, reg3 reads the result
    always @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < 16; i++) preg[i] <= 8'h00;
        else if (data_write) preg[address] <= data_in;
    assign data_out = (address == 4'd3) ? (preg[2][0] ? preg[0] - preg[1] : preg[0] + preg[1]) : preg[address];

    function automatic logic [7:0] mdl_rd(input logic [3:0] a);
        return (a == 4'd3) ? (mdl[2][0] ? mdl[0] - mdl[1] : mdl[0] + mdl[1]) : mdl[a];
    endfunction

    // Scoreboard: bus writes and read responses must follow accepted-command order
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        end else begin
            if (data_write) begin
                checks++;
                wr_cnt++;
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_write unexpected a=%h d=%h, none queued", address, data_in);
                end else begin
                    if (!exp_q[0].w || exp_q[0].a !== address || exp_q[0].d !== data_in) begin
                        errors++;
                        $display("FAIL bus_write got a=%h d=%h expected w=%0b a=%h d=%h",
                                 address, data_in, exp_q[0].w, exp_q[0].a, exp_q[0].d);
                    end
                    mdl[exp_q[0].a] = exp_q[0].d;
                    void'(exp_q.pop_front());
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp unexpected a=%h d=%h, none queued", rsp_addr, rsp_rdata);
                end else begin
                    if (exp_q[0].w || exp_q[0].a !== rsp_addr || mdl_rd(exp_q[0].a) !== rsp_rdata) begin
                        errors++;
                        $display("FAIL rsp got a=%h d=%h expected w=%0b a=%h d=%h",
                                 rsp_addr, rsp_rdata, exp_q[0].w, exp_q[0].a, mdl_rd(exp_q[0].a));
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(cmd_t'{cmd_write, cmd_addr, cmd_wdata});
        end
    end

    task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (!cmd_ready) begin errors++; $display("FAIL push_timeout cmd_ready=%0b required 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout rsp_valid=%0b required 1", rsp_valid); end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain busy=%0b pending=%0d required 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({level, cmd_ready, busy, data_write, address, rsp_valid, rsp_addr, rsp_rdata, data_in} !== {3'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state lvl=%0d rdy=%0b busy=%0b dw=%0b addr=%h rv=%0b ra=%h rd=%h di=%h required 0 1 0 0 0 0 0 0 0",
                     level, cmd_ready, busy, data_write, address, rsp_valid, rsp_addr, rsp_rdata, data_in);
        end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0 || data_write !== 1'b0 || address !== 4'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%0b dw=%0b addr=%h rv=%0b required 0 0 0 0", busy, data_write, address, rsp_valid);
        end
    endtask

    task automatic test_alu();
        int wc0 = wr_cnt;
        rsp_ready = 1'b1;
        push(1'b1, 4'h0, 8'h05);
        push(1'b1, 4'h1, 8'h03);
        push(1'b1, 4'h2, 8'h01);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wr_cnt != wc0 + 3 || wr_cyc[$] - wr_cyc[$-2] != 2) begin
            errors++;
            $display("FAIL alu_writes count=%0d span=%0d required 3 2", wr_cnt - wc0, wr_cyc[$] - wr_cyc[$-2]);
        end
        push(1'b0, 4'h3, 8'h00);
        wait_rsp();
        checks++;
        if (rsp_addr !== 4'h3 || rsp_rdata !== 8'h02) begin
            errors++;
            $display("FAIL alu_read got a=%h d=%h required 3 02", rsp_addr, rsp_rdata);
        end
        wait_idle();
    endtask

    task automatic test_stall();
        logic [3:0] sa;
        logic [7:0] sd;
        int wc0;
        rsp_ready = 1'b0;
        push(1'b0, 4'($urandom_range(0, 15)), 8'h00);
        wait_rsp();
        sa = rsp_addr; sd = rsp_rdata; wc0 = wr_cnt;
        for (int i = 0; i < 4; i++) push(1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
        checks++;
        if (level !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full level=%0d rdy=%0b required 4 0", level, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 8'hEE;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL stall_reject level=%0d required 4", level); end
        @(posedge clk); #1;
        checks++;
        if (wr_cnt != wc0 || rsp_valid !== 1'b1 || rsp_addr !== sa || rsp_rdata !== sd) begin
            errors++;
            $display("FAIL stall_hold writes=%0d rv=%0b a=%h d=%h required 0 1 %h %h", wr_cnt - wc0, rsp_valid, rsp_addr, rsp_rdata, sa, sd);
        end
        rsp_ready = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (wr_cnt != wc0 + 4 || wr_cyc[$] - wr_cyc[$-3] != 3) begin
            errors++;
            $display("FAIL stall_release count=%0d span=%0d required 4 3", wr_cnt - wc0, wr_cyc[$] - wr_cyc[$-3]);
        end
        wait_idle();
    endtask

    task automatic test_full_pop();
        rsp_ready = 1'b0;
        push(1'b0, 4'($urandom_range(0, 15)), 8'h00);
        wait_rsp();
        for (int i = 0; i < 4; i++) push(1'b0, 4'($urandom_range(0, 15)), 8'h00);
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL fullpop_start level=%0d required 4", level); end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'($urandom_range(0, 15)); cmd_wdata = 8'($urandom);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (level !== 3'd3) begin errors++; $display("FAIL fullpop_pop level=%0d required 3", level); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL fullpop_push level=%0d required 4", level); end
        rsp_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea, eb;
        rsp_ready = 1'b1;
        ea = mdl_rd(4'h0); eb = mdl_rd(4'h1);
        push(1'b0, 4'h0, 8'h00);
        push(1'b0, 4'h1, 8'h00);
        wait_rsp();
        checks++;
        if (rsp_addr !== 4'h0 || rsp_rdata !== ea) begin
            errors++;
            $display("FAIL b2b_first got a=%h d=%h required 0 %h", rsp_addr, rsp_rdata, ea);
        end
        @(posedge clk); #1;
        checks++;
        if (address !== 4'h1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overlap addr=%h rv=%0b required 1 0", address, rsp_valid);
        end
        wait_rsp();
        checks++;
        if (rsp_addr !== 4'h1 || rsp_rdata !== eb) begin
            errors++;
            $display("FAIL b2b_second got a=%h d=%h required 1 %h", rsp_addr, rsp_rdata, eb);
        end
        wait_idle();
    endtask

    task automatic test_random();
        rsp_ready = 1'b1;
        fork
            for (int i = 0; i < 24; i++) push(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            begin
                repeat (60) begin @(posedge clk); #1; rsp_ready = 1'($urandom_range(0, 1)); end
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int wc0;
        rsp_ready = 1'b0;
        push(1'b0, 4'h3, 8'h00);
        wait_rsp();
        push(1'b1, 4'h0, 8'h11);
        push(1'b1, 4'h1, 8'h22);
        checks++;
        if (level !== 3'd2 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_setup level=%0d rv=%0b required 2 1", level, rsp_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || data_write !== 1'b0 || level !== 3'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async rv=%0b dw=%0b level=%0d busy=%0b rdy=%0b required 0 0 0 0 1",
                     rsp_valid, data_write, level, busy, cmd_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        wc0 = wr_cnt;
        repeat (8) begin @(posedge clk); #1; end
        checks++;
        if (wr_cnt != wc0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale writes=%0d rv=%0b busy=%0b required 0 0 0", wr_cnt - wc0, rsp_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_stall();
        test_full_pop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_alu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/periph_bus_initiator.md
Name: periph_bus_initiator

Overview:
- Bus initiator for the TinyQV-style peripheral register interface: drives address / data_write / data_in and samples the peripheral's data_out.
- Accepts read and write commands over a valid/ready stream and buffers them in a small FIFO.
- Executes the commands in order and returns read data on a valid/ready response stream.
- Used as the test/host side for register peripherals (e.g. ALU blocks) and by the UART debug bridge.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- ADDR_W, 4, peripheral address width
- DATA_W, 8, peripheral data width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  response consumer ready
- rsp_addr  out  ADDR_W  address the read was issued to
- rsp_rdata  out  DATA_W  sampled read data
- address  out  ADDR_W  to peripheral
- data_write  out  1  to peripheral, one-cycle write strobe
- data_in  out  DATA_W  to peripheral, write data
- data_out  in  DATA_W  from peripheral; combinational function of address
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- busy  out  1  FIFO non-empty or state != IDLE

Behaviour:
- Reset (async assert, sync release) sets all of the following to 0: address, data_write, data_in, rsp_valid, rsp_addr, rsp_rdata, level, FIFO pointers. State = IDLE. cmd_ready = 1. busy = 0.
- All outputs except cmd_ready and busy are registered.
- Push: cmd_valid && cmd_ready at a clock edge stores {write, addr, wdata}.
  - Push while full is not accepted; cmd_ready is based on the current count, so a same-cycle pop does not help.
  - Push and pop in the same cycle, when not full, leave level unchanged.
- No bypass: a command pushed into an empty FIFO at edge N is popped at edge N+1 at the earliest.
- FSM states: IDLE, ISSUE, WAIT_RSP.
  - IDLE/ISSUE with FIFO non-empty: pop the head and go to ISSUE. At that edge register address = head.addr, data_in = head.wdata (writes only; otherwise hold), data_write = head.write.
  - IDLE/ISSUE with FIFO empty: go to IDLE, data_write = 0.
  - ISSUE for a write: data_write is high for exactly this one cycle. The next command may issue on the following edge, so back-to-back writes run at 1 per cycle.
  - ISSUE for a read: data_write = 0. data_out is sampled at the end of the ISSUE cycle into rsp_rdata, and address goes into rsp_addr. rsp_valid = 1 from the next cycle. Go to WAIT_RSP.
  - WAIT_RSP: hold rsp_* stable and issue nothing. FIFO pushes are still accepted. On rsp_valid && rsp_ready, clear rsp_valid and, at the same edge, pop the next command if one is present (state ISSUE), else go to IDLE.
- Latency for a read into an empty, idle block: cmd accepted at edge N, address driven after edge N+1, rsp_valid high after edge N+2.
- address holds its last value when idle. data_in changes only on write issue.
- Writes produce no response. Command order on the bus strictly equals push order.
- Reset mid-transaction aborts the transaction: the pending response and FIFO contents are discarded and data_write drops to 0 immediately (async).

Decomposition:
- Package periph_bus_pkg:
  - state enum {IDLE, ISSUE, WAIT_RSP}
  - ADDR_W / DATA_W defaults
  - cmd record layout: write, addr, wdata; width CMD_W = 1 + ADDR_W + DATA_W
- Sub-module periph_cmd_fifo:
  - Generic synchronous FIFO: width CMD_W, depth DEPTH, async active-high reset.
  - Ports: push / pop / full / empty / level.
- periph_bus_initiator instantiates one periph_cmd_fifo and contains the FSM and the bus/response registers.

Test Plan:
- Reset then idle -> level = 0, cmd_ready = 1, busy = 0, data_write = 0, address = 0x0, rsp_valid = 0.
- Push W(0x0, 0x05), W(0x1, 0x03), W(0x2, 0x01) on consecutive cycles against an ALU model -> data_write high on 3 consecutive cycles with address 0, 1, 2 and data_in 05, 03, 01. Then push R(0x3) -> rsp_valid with rsp_addr = 0x3, rsp_rdata = 0x02.
- Read with rsp_ready held low for 5 cycles while pushing 4 more writes -> rsp_rdata stable, no bus activity, level reaches 4, cmd_ready = 0. A 5th cmd_valid is not accepted. After rsp_ready goes high, the 4 writes issue on 4 consecutive cycles.
- Full FIFO with simultaneous pop and cmd_valid -> push rejected that cycle and accepted the next cycle. Level sequence 4, 3, 4.
- Back-to-back R(0x0), R(0x1) with rsp_ready = 1 -> second address is driven in the same edge as the first response handshake; rsp_rdata equals peripheral A, then B.
- Assert rst while in WAIT_RSP with 2 entries queued -> rsp_valid, data_write and level are 0 immediately. After release, no stale commands issue.
